sync_ram_ctrl: RTL and testbench
================================

SYNC_RAM_CTRL -- requirements
Module: sync_ram_ctrl

Interface
REQ-001 The block SHALL have parameter A_WIDTH, default 10, address width; depth = 2^A_WIDTH words.
REQ-002 The block SHALL have parameter D_WIDTH, default 128, word width; legal values are multiples of 8.
REQ-003 The block SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_rw  input  1  1 = read, 0 = write.
REQ-009 req_addr  input  A_WIDTH  word address.
REQ-010 req_wdata  input  D_WIDTH  write data.
REQ-011 req_wmask  input  D_WIDTH/8  per-byte write enable; bit i covers bits 8i+7..8i.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_rw  output  1  echo of the accepted req_rw.
REQ-015 resp_rdata  output  D_WIDTH  read data; all zeros whenever resp_valid=0 or resp_rw=0.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-017 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
REQ-018 On acceptance the block SHALL capture rw, addr, wdata and wmask, load the wait counter with LATENCY-1, and enter WAIT.
REQ-019 In WAIT the counter SHALL decrement each cycle, and on the edge where the counter is 0 the block SHALL perform the array operation and enter RESP.
REQ-020 resp_valid SHALL be 1 exactly in RESP, so the first response cycle is LATENCY+1 cycles after the acceptance edge.
REQ-021 A write SHALL update only the bytes whose captured wmask bit is 1, and an all-zero mask SHALL leave the word unchanged while still producing a response.
REQ-022 A read SHALL return the word as stored at the operation edge, including a write committed by the immediately preceding request to the same address.
REQ-023 In RESP, resp_valid, resp_rw and resp_rdata SHALL hold stable until resp_ready=1, and on that edge the block SHALL return to IDLE.
REQ-024 The block SHALL NOT accept a new request on the same edge that the response is accepted; the earliest new acceptance is one cycle later.
REQ-025 req_addr changes outside an acceptance edge SHALL have no effect, and address wrap is impossible by construction.

Reset
REQ-026 While rst=1 the block SHALL force state to IDLE, the counter to 0, resp_valid=0, resp_rw=0 and resp_rdata=0; req_ready is 0 during reset and 1 on the first cycle after reset.
REQ-027 Reset in WAIT SHALL abandon the request, and a write that has not reached its operation edge SHALL NOT be committed.
REQ-028 Reset in RESP SHALL drop the pending response.
REQ-029 Array contents SHALL NOT be reset.

Configuration
REQ-030 With SYNC_RAM_WMASK_EN defined, writes SHALL honour req_wmask as in REQ-021.
REQ-031 With SYNC_RAM_WMASK_EN undefined, req_wmask SHALL remain a port but be ignored, and every write SHALL update the full word.

Structure
REQ-032 Package sync_ram_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the RW_READ=1 and RW_WRITE=0 constants.
REQ-033 Storage SHALL be the sub-module sync_ram_array: one synchronous port, write with byte enables, registered read data, and no reset.
REQ-034 sync_ram_ctrl SHALL contain only the FSM, the counter, the capture registers and the output zeroing.

Verification
REQ-035 Bench: after reset, write 0xA5 replicated to addr 5 with full mask and LATENCY=2 -> req_ready drops, resp_valid rises on the 3rd cycle after acceptance, resp_rw=0, resp_rdata=0.
REQ-036 Bench: read addr 5 -> resp_rdata = 0xA5A5…A5, held unchanged while resp_ready is held 0 for 4 cycles, and cleared after the accept edge.
REQ-037 Bench: write 0xFF…FF to addr 5 with wmask=0x0001, then read -> low byte 0xFF and other bytes 0xA5 when SYNC_RAM_WMASK_EN is defined; all 0xFF when it is undefined.
REQ-038 Bench: assert rst in WAIT during a write of 0x1234 to addr 9 (prior content 0) -> a later read of addr 9 returns 0, and req_ready=1 on the cycle after reset deasserts.
REQ-039 Bench: hold req_valid=1 with back-to-back requests and resp_ready tied to 1 -> one acceptance every LATENCY+2 cycles, with no acceptance on any response-accept edge.
REQ-040 Bench: LATENCY=1 with A_WIDTH=4 -> write then read addr 15 -> correct data, resp_valid first asserted 2 cycles after acceptance.

Source files
------------

// File: rtl/sync_ram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sync_ram_pkg
// Brief  : Shared FSM state type and request-direction constants.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package sync_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/sync_ram_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sync_ram_array
// Brief  : Single-port synchronous RAM, byte-enable writes, registered read.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module sync_ram_array #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [A_WIDTH-1:0]     addr_i,
  input  logic [D_WIDTH-1:0]     wdata_i,
  input  logic [D_WIDTH/8-1:0]   be_i,
  output logic [D_WIDTH-1:0]     rdata_o
);

  logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];
  logic [D_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < D_WIDTH/8; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sync_ram_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sync_ram_ctrl
// Brief  : Request/response controller with fixed-latency access to a RAM.
// Config : SYNC_RAM_WMASK_EN - honour req_wmask on writes (else full-word).
// Rev    : 1.0
// ----------------------------------------------------------------------------
module sync_ram_ctrl
  import sync_ram_pkg::*;
#(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 128,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [A_WIDTH-1:0]   req_addr,
  input  logic [D_WIDTH-1:0]   req_wdata,
  input  logic [D_WIDTH/8-1:0] req_wmask,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_rw,
  output logic [D_WIDTH-1:0]   resp_rdata
);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rw_q;
  logic [A_WIDTH-1:0]   addr_q;
  logic [D_WIDTH-1:0]   wdata_q;
  logic [D_WIDTH/8-1:0] wmask_q;
  logic                 resp_valid_q;
  logic                 resp_rw_q;

  logic                 w_op;
  logic [D_WIDTH/8-1:0] w_be;
  logic [D_WIDTH-1:0]   w_rdata;

  // Gating with rst keeps an in-flight write from committing on a reset edge.
  assign w_op = (state_q == WAIT) && (cnt_q == '0) && !rst;

`ifdef SYNC_RAM_WMASK_EN
  assign w_be = wmask_q;
`else
  assign w_be = wmask_q | {(D_WIDTH/8){1'b1}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rw_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rw_q    <= rw_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rw_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_ram_array #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_array (
    .clk     (clk),
    .en_i    (w_op),
    .we_i    (rw_q == RW_WRITE),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .be_i    (w_be),
    .rdata_o (w_rdata)
  );

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q && !rst;
  assign resp_rw    = resp_rw_q && !rst;
  assign resp_rdata = (resp_valid_q && (resp_rw_q == RW_READ) && !rst) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_sync_ram_ctrl
// Brief  : Self-checking bench for sync_ram_ctrl (LATENCY=2 and LATENCY=1 builds).
// Config : SYNC_RAM_WMASK_EN selects masked-write expectations.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_sync_ram_ctrl;

  typedef struct {
    logic         rw;
    logic [9:0]   addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    int           hold;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic         rw;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, sel, req_valid, req_rw, resp_ready;
  logic [9:0]   req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wmask;

  logic         rr0, rv0, rrw0, rr1, rv1, rrw1;
  logic [127:0] rd0, rd1;
  logic         w_rr, w_rv, w_rrw;
  logic [127:0] w_rd;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sync_ram_ctrl #(.A_WIDTH(10), .D_WIDTH(128), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr0),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rw(rrw0), .resp_rdata(rd0)
  );

  sync_ram_ctrl #(.A_WIDTH(4), .D_WIDTH(128), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr1),
    .req_rw(req_rw), .req_addr(req_addr[3:0]), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rw(rrw1), .resp_rdata(rd1)
  );

  assign w_rr  = sel ? rr1  : rr0;
  assign w_rv  = sel ? rv1  : rv0;
  assign w_rrw = sel ? rrw1 : rrw0;
  assign w_rd  = sel ? rd1  : rd0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: response with empty scoreboard, got %0h, expected none", nm, w_rd);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_rw"}, 128'(w_rrw), 128'(e.rw));
    chk({nm, "_rdata"}, w_rd, e.data);
  endtask

  // Called and returning at a negedge with the selected DUT idle.
  task automatic do_req(input vec_t v, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (w_rr !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 128'(w_rr), 128'd1);
    req_valid = 1'b1;
    req_rw    = v.rw;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wmask = v.wmask;
    @(posedge clk);
    sb.push_back('{v.rw, v.rw ? v.exp : 128'd0});
    @(negedge clk);
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_addr  = 10'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    req_wmask = 16'($urandom);
    chk("req_ready_busy", 128'(w_rr), 128'd0);
    lat = 1;
    while (w_rv !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_latency", 128'(lat), 128'(exp_lat));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(w_rv), 128'd1);
      chk("hold_rdata", w_rd, v.rw ? v.exp : 128'd0);
    end
    resp_ready = 1'b1;
    sb_check("resp");
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_accept_valid", 128'(w_rv), 128'd0);
    chk("post_accept_rdata", w_rd, 128'd0);
    chk("post_accept_ready", 128'(w_rr), 128'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t         tv[11];
    logic [127:0] a5, ff, p, r, e_mask1, e_mask0;
    exp_t         e;
    int           last, nacc, n;
    logic         acc, racc;

    a5 = {16{8'hA5}};
    ff = '1;
    p  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    r  = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;
`ifdef SYNC_RAM_WMASK_EN
    e_mask1 = {{15{8'hA5}}, 8'hFF};
    e_mask0 = p;
`else
    e_mask1 = ff;
    e_mask0 = ~p;
`endif
    //             rw    addr      wdata  wmask       hold exp
    tv[0]  = '{1'b0, 10'd5,    a5,    16'hFFFF,  0,   128'd0};
    tv[1]  = '{1'b1, 10'd5,    '0,    16'h0000,  4,   a5};
    tv[2]  = '{1'b0, 10'd5,    ff,    16'h0001,  0,   128'd0};
    tv[3]  = '{1'b1, 10'd5,    '0,    16'h0000,  1,   e_mask1};
    tv[4]  = '{1'b0, 10'd7,    p,     16'hFFFF,  0,   128'd0};
    tv[5]  = '{1'b0, 10'd7,    ~p,    16'h0000,  2,   128'd0};
    tv[6]  = '{1'b1, 10'd7,    '0,    16'hFFFF,  0,   e_mask0};
    tv[7]  = '{1'b0, 10'd9,    '0,    16'hFFFF,  0,   128'd0};
    tv[8]  = '{1'b0, 10'd1023, r,     16'hFFFF,  0,   128'd0};
    tv[9]  = '{1'b1, 10'd1023, '0,    16'h0000,  0,   r};
    tv[10] = '{1'b1, 10'd9,    '0,    16'h0000,  0,   128'd0};

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_rw = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(rr0), 128'd0);
    chk("rst_resp_valid", 128'(rv0), 128'd0);
    chk("rst_resp_rw", 128'(rrw0), 128'd0);
    chk("rst_resp_rdata", rd0, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", 128'(rr0), 128'd1);
    chk("post_rst_ready1", 128'(rr1), 128'd1);

    for (int i = 0; i < 10; i++) do_req(tv[i], 3);

    // Reset lands on the write's operation edge: the write must be dropped.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 10'd9;
    req_wdata = 128'h1234; req_wmask = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wait_rst_ready", 128'(rr0), 128'd0);
    chk("wait_rst_valid", 128'(rv0), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("wait_rst_ready_after", 128'(rr0), 128'd1);
    chk("wait_rst_valid_after", 128'(rv0), 128'd0);
    do_req(tv[10], 3);

    // Back-to-back reads with resp_ready tied high.
    resp_ready = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = 10'd5;
    last = -1; nacc = 0;
    for (int c = 0; c < 26; c++) begin
      acc  = w_rr && req_valid;
      racc = w_rv && resp_ready;
      chk("b2b_no_overlap", 128'(acc && racc), 128'd0);
      if (racc) sb_check("b2b");
      if (acc) begin
        if (last >= 0) chk("b2b_period", 128'(c - last), 128'd4);
        last = c;
        nacc++;
        sb.push_back('{1'b1, e_mask1});
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      if (w_rv) sb_check("b2b_drain");
      @(negedge clk);
      n++;
    end
    resp_ready = 1'b0;
    chk("b2b_drained", 128'(sb.size()), 128'd0);
    chk("b2b_accepts", 128'(nacc), 128'd7);

    // LATENCY=1, A_WIDTH=4 instance: top address.
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    do_req('{1'b0, 10'd15, r, 16'hFFFF, 1, 128'd0}, 2);
    do_req('{1'b1, 10'd15, '0, 16'h0000, 1, r}, 2);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
